miner_controller: RTL and testbench

- Top-level sequencing FSM for one mining core.
- Drives the 3-bit controller_state consumed by the shift timer: in 000 the timer clears; in 001 and 010 it counts.
- Uses the timer's midstate_shifts_done and remaining_shifts_done flags to advance from midstate load to remaining-block load.
- Then runs the SHA core once per nonce, checks each result against the target, and reports found or exhausted to the host.

---
 rtl/miner_controller.sv | 214 +++++++++++++++++++++
 tb/tb_miner_controller.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miner_controller.sv
// miner_controller: top-level sequencing FSM for one mining core.
//
// Flow: IDLE -> LOAD_MID -> LOAD_REM -> HASH -> CHECK -> (HASH | FOUND | EXHAUSTED).
// The 3-bit state register is presented directly on controller_state. The
// companion shift timer reads it: the timer clears in 000 and counts in 001/010.
//
// Optional feature macro: HASH_WATCHDOG_EN. When it is defined, a per-nonce
// watchdog moves HASH to TIMEOUT (111) after HASH_TIMEOUT cycles without
// hash_done. When it is not defined, no counter is built and code 111 is an
// illegal state that recovers to IDLE.
//
// Host handshake: start and ack are level inputs sampled on the rising clock
// edge. start is accepted only in IDLE. ack is accepted only while
// found/exhausted/timeout is high, and the FSM returns to IDLE on the edge that
// samples it. abort is accepted on any edge, outranks every other input, and
// forces IDLE on the next cycle.
module miner_controller #(
    parameter int unsigned          NONCE_W      = 32,
    parameter logic [NONCE_W-1:0]   NONCE_START  = '0,
    parameter int unsigned          HASH_TIMEOUT = 200
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic               ack,
    input  logic               midstate_shifts_done,
    input  logic               remaining_shifts_done,
    input  logic               hash_done,
    input  logic               hash_meets_target,
    output logic [2:0]         controller_state,
    output logic               shift_enable,
    output logic               sha_start,
    output logic [NONCE_W-1:0] nonce,
    output logic               found,
    output logic               exhausted,
    output logic               timeout,
    output logic               busy
);

    // State codes are visible to the timer, so the encoding is fixed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_LOAD_MID  = 3'b001,
        ST_LOAD_REM  = 3'b010,
        ST_HASH      = 3'b011,
        ST_CHECK     = 3'b100,
        ST_FOUND     = 3'b101,
        ST_EXHAUSTED = 3'b110,
        ST_TIMEOUT   = 3'b111
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               sha_start_q;
    logic               meets_q;
    logic [NONCE_W-1:0] nonce_q;
    logic               nonce_is_max;
    logic               hash_expired;

    assign nonce_is_max = &nonce_q;

`ifdef HASH_WATCHDOG_EN
    // Wide enough to hold HASH_TIMEOUT itself.
    localparam int WD_W = (HASH_TIMEOUT < 1) ? 1 : $clog2(HASH_TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;

    assign hash_expired = (wd_cnt == WD_W'(HASH_TIMEOUT));

    // The watchdog is zero on every HASH entry (including re-entry from CHECK)
    // and counts HASH cycles. It stops at the limit because HASH is left there.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wd_cnt <= '0;
        end else if (state != ST_HASH) begin
            wd_cnt <= '0;
        end else if (!hash_expired) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    // No watchdog in this build: HASH waits for hash_done indefinitely.
    assign hash_expired = 1'b0;

    // HASH_TIMEOUT only has an effect when the watchdog is built.
    logic unused_hash_timeout;
    assign unused_hash_timeout = (HASH_TIMEOUT != 0) & hash_expired;
`endif

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the outputs decoded from the registered state.
    // abort is applied last so that it overrides every other transition.
    always_comb begin
        state_next   = state;
        shift_enable = 1'b0;
        found        = 1'b0;
        exhausted    = 1'b0;
        timeout      = 1'b0;
        busy         = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD_MID;
                end
            end
            ST_LOAD_MID: begin
                // remaining_shifts_done is ignored in this state.
                shift_enable = 1'b1;
                if (midstate_shifts_done) begin
                    state_next = ST_LOAD_REM;
                end
            end
            ST_LOAD_REM: begin
                shift_enable = 1'b1;
                if (remaining_shifts_done) begin
                    state_next = ST_HASH;
                end
            end
            ST_HASH: begin
                // If hash_done arrives on the watchdog-limit cycle, hash_done wins.
                if (hash_done) begin
                    state_next = ST_CHECK;
                end else if (hash_expired) begin
                    state_next = ST_TIMEOUT;
                end
            end
            ST_CHECK: begin
                if (meets_q) begin
                    state_next = ST_FOUND;
                end else if (nonce_is_max) begin
                    state_next = ST_EXHAUSTED;
                end else begin
                    state_next = ST_HASH;
                end
            end
            ST_FOUND: begin
                found = 1'b1;
                if (ack) begin
                    state_next = ST_IDLE;
                end
            end
            ST_EXHAUSTED: begin
                exhausted = 1'b1;
                if (ack) begin
                    state_next = ST_IDLE;
                end
            end
            ST_TIMEOUT: begin
`ifdef HASH_WATCHDOG_EN
                timeout = 1'b1;
                if (ack) begin
                    state_next = ST_IDLE;
                end
`else
                // Unreachable in this build; recover if it is ever entered.
                state_next = ST_IDLE;
`endif
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_next = ST_IDLE;
        end
    end

    // Entry flag: high during the first HASH cycle after any entry, so the
    // core is launched exactly once per nonce.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sha_start_q <= 1'b0;
        end else begin
            sha_start_q <= (state_next == ST_HASH) && (state != ST_HASH);
        end
    end

    // Capture the compare result on the hash_done cycle. CHECK uses it on the next cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meets_q <= 1'b0;
        end else if ((state == ST_HASH) && hash_done) begin
            meets_q <= hash_meets_target;
        end
    end

    // Nonce: loaded when a job starts and advanced only on CHECK -> HASH.
    // It therefore stays unchanged in FOUND and stays all ones in EXHAUSTED.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            nonce_q <= NONCE_START;
        end else if ((state == ST_IDLE) && (state_next == ST_LOAD_MID)) begin
            nonce_q <= NONCE_START;
        end else if ((state == ST_CHECK) && (state_next == ST_HASH)) begin
            nonce_q <= nonce_q + NONCE_W'(1);
        end
    end

    assign controller_state = state;
    assign sha_start        = sha_start_q;
    assign nonce            = nonce_q;

endmodule

// File: tb/tb_miner_controller.sv
// tb_miner_controller: drives two controller instances (NONCE_START = 0 and
// NONCE_START = 32'hFFFFFFFE) with a shift-timer model and a SHA-core
// responder. A scoreboard checks every sha_start pulse and every
// found/exhausted/timeout assertion against a job-level reference model.
// Direct checks cover state durations, reset values and boundary cases.
module tb_miner_controller;

    localparam int NW   = 32;
    localparam int EV_W = 1 + 3 + NW;   // {instance, kind, nonce}

    localparam logic [2:0] EV_SHA   = 3'd1;
    localparam logic [2:0] EV_FOUND = 3'd2;
    localparam logic [2:0] EV_EXH   = 3'd3;
    localparam logic [2:0] EV_TMO   = 3'd4;

    // State codes as the timer and host see them.
    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_MID   = 3'b001;
    localparam logic [2:0] S_REM   = 3'b010;
    localparam logic [2:0] S_HASH  = 3'b011;
    localparam logic [2:0] S_CHECK = 3'b100;
    localparam logic [2:0] S_FOUND = 3'b101;
    localparam logic [2:0] S_EXH   = 3'b110;
    localparam logic [2:0] S_TMO   = 3'b111;

    // Clock and reset.
    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    // Per-instance host inputs and DUT outputs.
    logic          start [2];
    logic          abort [2];
    logic          ack   [2];
    logic [2:0]    cs    [2];
    logic          shift_en [2];
    logic          sha_start [2];
    logic [NW-1:0] nonce_o [2];
    logic          found [2];
    logic          exhausted [2];
    logic          timeout [2];
    logic          busy [2];
    logic          hash_done_w [2];
    logic          meets_w [2];
    logic          mid_done [2];
    logic          rem_done [2];

    // SHA responder configuration.
    int            lat [2];
    bit            hold [2];
    bit            meet_en [2];
    logic [NW-1:0] meet_nonce [2];

    int n_checks = 0;
    int n_fail   = 0;
    logic [EV_W-1:0] exp_q[$];

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [5:0]    shift_cnt;
        int            hd_cnt   = 0;
        logic [NW-1:0] hd_nonce = '0;
        logic          hd       = 1'b0;
        logic          hm       = 1'b0;

        miner_controller #(
            .NONCE_W      (NW),
            .NONCE_START  (g == 0 ? 32'h0000_0000 : 32'hFFFF_FFFE),
            .HASH_TIMEOUT (20)
        ) dut (
            .clk                   (clk),
            .n_rst                 (n_rst),
            .start                 (start[g]),
            .abort                 (abort[g]),
            .ack                   (ack[g]),
            .midstate_shifts_done  (mid_done[g]),
            .remaining_shifts_done (rem_done[g]),
            .hash_done             (hash_done_w[g]),
            .hash_meets_target     (meets_w[g]),
            .controller_state      (cs[g]),
            .shift_enable          (shift_en[g]),
            .sha_start             (sha_start[g]),
            .nonce                 (nonce_o[g]),
            .found                 (found[g]),
            .exhausted             (exhausted[g]),
            .timeout               (timeout[g]),
            .busy                  (busy[g])
        );

        // Companion shift timer: cleared in 000, counts in 001/010, holds otherwise.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                shift_cnt <= '0;
            end else if (cs[g] == S_IDLE) begin
                shift_cnt <= '0;
            end else if (cs[g] == S_MID || cs[g] == S_REM) begin
                shift_cnt <= shift_cnt + 6'd1;
            end
        end
        assign mid_done[g] = (shift_cnt == 6'd8);
        assign rem_done[g] = (shift_cnt == 6'd24);

        // SHA core model: hash_done is a one-cycle pulse lat cycles after sha_start.
        always @(posedge clk) begin
            #1;
            hd = 1'b0;
            hm = 1'b0;
            if (!n_rst) begin
                hd_cnt = 0;
            end else begin
                if (hd_cnt > 0) begin
                    hd_cnt--;
                    if (hd_cnt == 0 && !hold[g]) begin
                        hd = 1'b1;
                        hm = meet_en[g] && (hd_nonce == meet_nonce[g]);
                    end
                end
                if (sha_start[g]) begin
                    hd_cnt   = lat[g];
                    hd_nonce = nonce_o[g];
                end
            end
        end
        assign hash_done_w[g] = hd;
        assign meets_w[g]     = hm;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NW-1:0] start_of(input int i);
        return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFFE;
    endfunction

    task automatic push_ev(input int i, input logic [2:0] k, input logic [NW-1:0] n);
        exp_q.push_back({1'(i), k, n});
    endtask

    // Reference model for a whole job: walk the nonces from the start value and
    // list the host-visible events that should follow.
    task automatic model_job(input int i, input bit use_meet, input logic [NW-1:0] m, input bit tmo);
        logic [NW-1:0] n;
        n = start_of(i);
        meet_en[i]    = use_meet;
        meet_nonce[i] = m;
        for (int k = 0; k < 64; k++) begin
            push_ev(i, EV_SHA, n);
            if (tmo) begin
                push_ev(i, EV_TMO, n);
                return;
            end
            if (use_meet && n == m) begin
                push_ev(i, EV_FOUND, n);
                return;
            end
            if (n == '1) begin
                push_ev(i, EV_EXH, n);
                return;
            end
            n = n + 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_job(input int i);
        step();
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
    endtask

    task automatic do_ack(input int i);
        ack[i] = 1'b1;
        step();
        ack[i] = 1'b0;
    endtask

    // Bounded wait: 0 found, 1 exhausted, 2 timeout, 3 in HASH, 4 hash_done, 5 found|exhausted.
    task automatic wait_cond(input int i, input int what, input int bound, input string name);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < bound && !hit; c++) begin
            case (what)
                0:       hit = found[i];
                1:       hit = exhausted[i];
                2:       hit = timeout[i];
                3:       hit = (cs[i] == S_HASH);
                4:       hit = hash_done_w[i];
                default: hit = found[i] || exhausted[i];
            endcase
            if (!hit) step();
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: condition not reached within %0d cycles", name, bound);
        end
    endtask

    task automatic count_run(input int i, input logic [2:0] code, output int n, output int se_low);
        n = 0;
        se_low = 0;
        while (cs[i] == code && n < 400) begin
            n++;
            if (!shift_en[i]) se_low++;
            step();
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic sb_compare(input int i, input string name, input logic [2:0] k, input logic [NW-1:0] n);
        logic [EV_W-1:0] act;
        logic [EV_W-1:0] exp;
        act = {1'(i), k, n};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_%s: got event %h, expected no event", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL sb_%s: got event %h, expected %h", name, act, exp);
            end
        end
    endtask

    logic found_p [2] = '{1'b0, 1'b0};
    logic exh_p   [2] = '{1'b0, 1'b0};
    logic tmo_p   [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (sha_start[i] === 1'b1)          sb_compare(i, "sha_start", EV_SHA, nonce_o[i]);
            if (found[i] && !found_p[i])        sb_compare(i, "found", EV_FOUND, nonce_o[i]);
            if (exhausted[i] && !exh_p[i])      sb_compare(i, "exhausted", EV_EXH, nonce_o[i]);
            if (timeout[i] && !tmo_p[i])        sb_compare(i, "timeout", EV_TMO, nonce_o[i]);
            found_p[i] = found[i];
            exh_p[i]   = exhausted[i];
            tmo_p[i]   = timeout[i];
        end
    end

    // Absolute time bound for the whole run.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: run did not finish, expected completion");
        $fatal(1, "time limit");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int se_low;
        int pick;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; abort[i] = 1'b0; ack[i] = 1'b0;
            lat[i] = 10; hold[i] = 1'b0; meet_en[i] = 1'b0; meet_nonce[i] = '0;
        end

        // Power-on reset values.
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            check("por_state", cs[i], S_IDLE);
            check("por_nonce", nonce_o[i], start_of(i));
            check("por_flags", {shift_en[i], sha_start[i], found[i], exhausted[i], timeout[i], busy[i]}, 6'b0);
        end
        n_rst = 1'b1;
        step();

        // Asynchronous reset during LOAD_REM.
        start_job(0);
        repeat (15) step();
        check("pre_reset_rem", cs[0], S_REM);
        #1;
        n_rst = 1'b0;
        #1;
        check("async_rst_state", cs[0], S_IDLE);
        check("async_rst_nonce", nonce_o[0], 32'h0);
        check("async_rst_flags", {shift_en[0], sha_start[0], found[0], exhausted[0], timeout[0], busy[0]}, 6'b0);
        exp_q.delete();
        step();
        n_rst = 1'b1;
        step();

        // Load timing with the timer, then nonces 0,1,2 with target met on nonce 2.
        lat[0] = 10;
        model_job(0, 1'b1, 32'd2, 1'b0);
        start_job(0);
        count_run(0, S_MID, n, se_low);
        check("load_mid_cycles", n, 9);
        check("load_mid_shift_low", se_low, 0);
        count_run(0, S_REM, n, se_low);
        check("load_rem_cycles", n, 16);
        check("load_rem_shift_low", se_low, 0);
        check("hash_entry", cs[0], S_HASH);
        check("hash_shift_off", shift_en[0], 1'b0);
        wait_cond(0, 0, 300, "wait_found");
        check("found_nonce", nonce_o[0], 32'd2);
        check("found_state", cs[0], S_FOUND);
        do_ack(0);
        check("ack_idle", cs[0], S_IDLE);
        check("ack_flags", {found[0], busy[0]}, 2'b00);
        check("nonce_held_idle", nonce_o[0], 32'd2);

        // Exhaustion at the top of the nonce range.
        lat[1] = $urandom_range(1, 12);
        model_job(1, 1'b0, '0, 1'b0);
        start_job(1);
        wait_cond(1, 1, 300, "wait_exhausted");
        check("exh_nonce", nonce_o[1], 32'hFFFF_FFFF);
        repeat (5) step();
        check("exh_hold_state", cs[1], S_EXH);
        check("exh_no_wrap", nonce_o[1], 32'hFFFF_FFFF);
        do_ack(1);
        check("exh_ack_idle", {cs[1], exhausted[1]}, {S_IDLE, 1'b0});

        // abort on the same cycle as hash_done with the target met.
        lat[0] = 10;
        model_job(0, 1'b1, 32'd0, 1'b0);
        start_job(0);
        wait_cond(0, 4, 300, "wait_hash_done");
        check("abort_in_hash", cs[0], S_HASH);
        abort[0] = 1'b1;
        exp_q.delete();
        step();
        abort[0] = 1'b0;
        check("abort_idle", cs[0], S_IDLE);
        repeat (20) step();
        check("abort_no_found", {found[0], cs[0]}, {1'b0, S_IDLE});
        model_job(0, 1'b1, 32'd1, 1'b0);
        start_job(0);
        check("restart_state", cs[0], S_MID);
        check("restart_nonce", nonce_o[0], 32'd0);
        wait_cond(0, 0, 300, "wait_found_restart");
        check("restart_found_nonce", nonce_o[0], 32'd1);
        do_ack(0);

        // Randomised jobs on both instances.
        for (int r = 0; r < 6; r++) begin
            lat[0] = $urandom_range(1, 12);
            model_job(0, 1'b1, 32'($urandom_range(0, 4)), 1'b0);
            start_job(0);
            wait_cond(0, 0, 400, "rand_wait_found");
            repeat ($urandom_range(0, 4)) step();
            check("rand_found_level", found[0], 1'b1);
            do_ack(0);
            check("rand_ack_idle", cs[0], S_IDLE);
        end
        for (int r = 0; r < 3; r++) begin
            lat[1] = $urandom_range(1, 12);
            pick = $urandom_range(0, 2);
            model_job(1, pick != 2, (pick == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF, 1'b0);
            start_job(1);
            wait_cond(1, 5, 400, "rand_wait_end");
            repeat ($urandom_range(0, 4)) step();
            do_ack(1);
            check("rand1_ack_idle", {cs[1], busy[1]}, {S_IDLE, 1'b0});
        end

`ifdef HASH_WATCHDOG_EN
        // Watchdog: hash_done withheld, so TIMEOUT is taken after 21 HASH cycles.
        hold[0] = 1'b1;
        model_job(0, 1'b0, '0, 1'b1);
        start_job(0);
        wait_cond(0, 3, 100, "wd_wait_hash");
        count_run(0, S_HASH, n, se_low);
        check("wd_hash_cycles", n, 21);
        check("wd_state", {cs[0], timeout[0]}, {S_TMO, 1'b1});
        repeat (3) step();
        check("wd_hold", cs[0], S_TMO);
        do_ack(0);
        check("wd_ack_idle", {cs[0], timeout[0]}, {S_IDLE, 1'b0});
        hold[0] = 1'b0;

        // hash_done on the limit cycle goes to CHECK instead.
        lat[0] = 20;
        model_job(0, 1'b1, 32'd0, 1'b0);
        start_job(0);
        wait_cond(0, 3, 100, "wd2_wait_hash");
        count_run(0, S_HASH, n, se_low);
        check("wd2_hash_cycles", n, 21);
        check("wd2_check", cs[0], S_CHECK);
        wait_cond(0, 0, 50, "wd2_wait_found");
        do_ack(0);
`else
        // Without the watchdog, HASH waits indefinitely for hash_done.
        hold[0] = 1'b1;
        meet_en[0] = 1'b0;
        push_ev(0, EV_SHA, 32'd0);
        start_job(0);
        wait_cond(0, 3, 100, "nowd_wait_hash");
        repeat (300) step();
        check("nowd_still_hash", {cs[0], timeout[0]}, {S_HASH, 1'b0});
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        check("nowd_abort_idle", cs[0], S_IDLE);
        hold[0] = 1'b0;
`endif

        repeat (5) step();
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
